ps2_controller: RTL and testbench

Host-side PS/2 serial controller that connects the system clock domain to an open-drain PS/2 device, such as a mouse or keyboard. It receives 11-bit device-to-host frames and presents each valid byte with a one-cycle strobe. It also transmits single command bytes using the host-to-device request-to-send protocol, reporting either completion or timeout. Peripheral wrappers such as the mouse device instantiate it to send commands and collect data bytes.

---
 rtl/ps2_controller_if.sv | 28 ++
 rtl/ps2_controller.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ps2_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_controller_if.sv
// Host-side command/data bus of the PS/2 controller.
// The wrapper drives the command request and consumes the receive strobe and status pulses.
interface ps2_controller_if;
    logic [7:0] the_command;
    logic       send_command;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    modport master (
        output the_command,
        output send_command,
        input  received_data,
        input  received_data_en,
        input  command_was_sent,
        input  error_communication_timed_out
    );

    modport slave (
        input  the_command,
        input  send_command,
        output received_data,
        output received_data_en,
        output command_was_sent,
        output error_communication_timed_out
    );
endinterface

// File: rtl/ps2_controller.sv
// PS/2 host controller: receives device frames on filtered clock ticks and sends single
// command bytes with the request-to-send handshake.
//
// state      | meaning
// S_IDLE     | lines released; waits for a pending command while the receiver is idle
// S_INHIBIT  | PS2_CLK held low for INHIBIT_CYCLES
// S_RTS      | PS2_DAT low (start bit), PS2_CLK released
// S_WAIT_CLK | waits for the first device tick, bounded by START_TIMEOUT_CYCLES
// S_SEND     | ticks 2..10 shift out d1..d7, parity, then release for the stop bit
// S_ACK      | tick 11 samples the device ACK
// S_WAIT_IDLE| waits for both lines high before reporting completion
module ps2_controller #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000,
    parameter int RX_TIMEOUT_CYCLES    = 10000,
    parameter int FILTER_CYCLES        = 8
) (
    input  logic            CLOCK_50,
    input  logic            reset_n,
    ps2_controller_if.slave bus,
    inout  wire             PS2_CLK,
    inout  wire             PS2_DAT
);

    localparam int TX_MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int TX_MAX   = (TX_MAX_A > XFER_TIMEOUT_CYCLES) ? TX_MAX_A : XFER_TIMEOUT_CYCLES;
    localparam int TXW      = $clog2(TX_MAX + 1);
    localparam int RXW      = $clog2(RX_TIMEOUT_CYCLES + 1);
    localparam int FW       = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_WAIT_CLK, S_SEND, S_ACK, S_WAIT_IDLE
    } tx_state_t;

    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            clk_filt_q, clk_filt_d;
    logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
    logic            tick;

    logic            rx_active_q, rx_active_d;
    logic [3:0]      rx_cnt_q, rx_cnt_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_par_q, rx_par_d;
    logic [RXW-1:0]  rx_tmr_q, rx_tmr_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_en_q, rx_en_d;

    tx_state_t       state_q, state_d;
    logic [TXW-1:0]  tx_tmr_q, tx_tmr_d;
    logic [3:0]      tx_cnt_q, tx_cnt_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            pending_q, pending_d;
    logic            send_prev_q;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;
    logic            sent_q, sent_d;
    logic            err_q, err_d;
    logic            pending_clr;
    logic            abort;

    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    assign bus.received_data                 = rx_data_q;
    assign bus.received_data_en              = rx_en_q;
    assign bus.command_was_sent              = sent_q;
    assign bus.error_communication_timed_out = err_q;

    // The filtered clock only follows the synchronized line after FILTER_CYCLES agreeing samples.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        tick       = 1'b0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
                clk_filt_d = clk_s2_q;
                tick       = clk_filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rx_active_d = rx_active_q;
        rx_cnt_d    = rx_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_tmr_d    = rx_tmr_q;
        rx_data_d   = rx_data_q;
        rx_en_d     = 1'b0;
        if (rx_active_q) begin
            if (tick) begin
                rx_tmr_d = RXW'(RX_TIMEOUT_CYCLES - 1);
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q <= 4'd8) begin
                    rx_shift_d = {dat_s2_q, rx_shift_q[7:1]};
                end else if (rx_cnt_q == 4'd9) begin
                    rx_par_d = dat_s2_q;
                end else begin
                    rx_active_d = 1'b0;
                    if (dat_s2_q && (^{rx_shift_q, rx_par_q})) begin
                        rx_data_d = rx_shift_q;
                        rx_en_d   = 1'b1;
                    end
                end
            end else if (rx_tmr_q == '0) begin
                rx_active_d = 1'b0;
            end else begin
                rx_tmr_d = rx_tmr_q - 1'b1;
            end
        end else if (tick && !dat_s2_q && (state_q == S_IDLE) && !pending_q) begin
            // A queued command takes the bus before a new frame can start.
            rx_active_d = 1'b1;
            rx_cnt_d    = 4'd1;
            rx_tmr_d    = RXW'(RX_TIMEOUT_CYCLES - 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_tmr_d    = tx_tmr_q;
        tx_cnt_d    = tx_cnt_q;
        tx_byte_d   = tx_byte_q;
        clk_oe_d    = clk_oe_q;
        dat_oe_d    = dat_oe_q;
        sent_d      = 1'b0;
        err_d       = 1'b0;
        pending_clr = 1'b0;
        abort       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q && !rx_active_q) begin
                    state_d     = S_INHIBIT;
                    tx_tmr_d    = TXW'(INHIBIT_CYCLES - 1);
                    tx_byte_d   = cmd_q;
                    clk_oe_d    = 1'b1;
                    dat_oe_d    = 1'b0;
                    pending_clr = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (tx_tmr_q == '0) begin
                    state_d  = S_RTS;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                end else begin
                    tx_tmr_d = tx_tmr_q - 1'b1;
                end
            end
            S_RTS: begin
                state_d  = S_WAIT_CLK;
                tx_tmr_d = TXW'(START_TIMEOUT_CYCLES - 1);
            end
            S_WAIT_CLK: begin
                if (tick) begin
                    state_d  = S_SEND;
                    tx_cnt_d = 4'd1;
                    dat_oe_d = ~tx_byte_q[0];
                    tx_tmr_d = TXW'(XFER_TIMEOUT_CYCLES - 1);
                end else if (tx_tmr_q == '0) begin
                    abort = 1'b1;
                end else begin
                    tx_tmr_d = tx_tmr_q - 1'b1;
                end
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
                if (tx_tmr_q == '0) begin
                    abort = 1'b1;
                end else begin
                    tx_tmr_d = tx_tmr_q - 1'b1;
                    if (state_q == S_SEND && tick) begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                        if (tx_cnt_q <= 4'd7) begin
                            dat_oe_d = ~tx_byte_q[tx_cnt_q[2:0]];
                        end else if (tx_cnt_q == 4'd8) begin
                            // Odd parity bit is ~^byte; the line is pulled low when it is 0.
                            dat_oe_d = ^tx_byte_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = S_ACK;
                        end
                    end else if (state_q == S_ACK && tick) begin
                        if (!dat_s2_q) state_d = S_WAIT_IDLE;
                        else           abort   = 1'b1;
                    end else if (state_q == S_WAIT_IDLE && clk_s2_q && dat_s2_q) begin
                        sent_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err_d    = 1'b1;
        end
    end

    always_comb begin
        cmd_d     = cmd_q;
        pending_d = pending_q & ~pending_clr;
        if (bus.send_command && !send_prev_q) begin
            cmd_d     = bus.the_command;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            rx_active_q <= 1'b0;
            rx_cnt_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_q    <= 1'b0;
            rx_tmr_q    <= '0;
            rx_data_q   <= '0;
            rx_en_q     <= 1'b0;
            state_q     <= S_IDLE;
            tx_tmr_q    <= '0;
            tx_cnt_q    <= '0;
            tx_byte_q   <= '0;
            cmd_q       <= '0;
            pending_q   <= 1'b0;
            send_prev_q <= 1'b0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
            sent_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_s1_q    <= PS2_CLK;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= PS2_DAT;
            dat_s2_q    <= dat_s1_q;
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            rx_active_q <= rx_active_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_q    <= rx_par_d;
            rx_tmr_q    <= rx_tmr_d;
            rx_data_q   <= rx_data_d;
            rx_en_q     <= rx_en_d;
            state_q     <= state_d;
            tx_tmr_q    <= tx_tmr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_byte_q   <= tx_byte_d;
            cmd_q       <= cmd_d;
            pending_q   <= pending_d;
            send_prev_q <= bus.send_command;
            clk_oe_q    <= clk_oe_d;
            dat_oe_q    <= dat_oe_d;
            sent_q      <= sent_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_controller.sv
// Bench for ps2_controller: an open-drain device model exercises receive and transmit,
// with a frame-level reference model of which bytes must be delivered.
module tb_ps2_controller;
    localparam int INHIBIT = 50;
    localparam int START_TO = 1500;
    localparam int XFER_TO = 3000;
    localparam int RX_TO = 300;
    localparam int FILT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic dev_clk_lo = 1'b0;
    logic dev_dat_lo = 1'b0;
    wire  ps2_clk;
    wire  ps2_dat;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_lo ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_lo ? 1'b0 : 1'bz;

    ps2_controller_if bus ();

    ps2_controller #(
        .INHIBIT_CYCLES(INHIBIT), .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES(XFER_TO), .RX_TIMEOUT_CYCLES(RX_TO), .FILTER_CYCLES(FILT)
    ) u_dut (
        .CLOCK_50(clk), .reset_n(reset_n), .bus(bus), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int en_run = 0, en_max = 0, sent_run = 0, sent_max = 0, err_run = 0, err_max = 0;
    int sent_cnt = 0, err_cnt = 0;

    always @(negedge clk) begin
        if (bus.received_data_en) rx_q.push_back(bus.received_data);
        if (bus.command_was_sent && sent_run == 0) sent_cnt++;
        if (bus.error_communication_timed_out && err_run == 0) err_cnt++;
        en_run   = bus.received_data_en ? en_run + 1 : 0;
        sent_run = bus.command_was_sent ? sent_run + 1 : 0;
        err_run  = bus.error_communication_timed_out ? err_run + 1 : 0;
        if (en_run > en_max) en_max = en_run;
        if (sent_run > sent_max) sent_max = sent_run;
        if (err_run > err_max) err_max = err_run;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Device-to-host frame; the model decides from the bits on the wire whether a byte is due.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f[0] = 1'b0;
        f[8:1] = b;
        f[9] = (($countones(b) % 2) == 0) ^ bad_par;
        f[10] = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            dev_dat_lo = ~f[i];
            cyc(10);
            dev_clk_lo = 1'b1;
            cyc(20);
            dev_clk_lo = 1'b0;
            cyc(10);
        end
        dev_dat_lo = 1'b0;
        if (nbits == 11 && f[0] == 1'b0 && f[10] == 1'b1 && ($countones(f[9:1]) % 2) == 1)
            exp_q.push_back(b);
    endtask

    // Device side of a host-to-device transfer: bits[1..8] data, [9] parity, [10] stop.
    task automatic dev_host_rx(input int npulses, input bit do_ack, output logic [10:0] bits,
                               output int inh_len, output bit rts_ok, output bit found);
        int n;
        bits = '0;
        inh_len = 0;
        rts_ok = 1'b0;
        found = 1'b0;
        n = 0;
        while (ps2_clk !== 1'b0 && n < 20000) begin cyc(1); n++; end
        if (ps2_clk !== 1'b0) return;
        found = 1'b1;
        while (ps2_clk === 1'b0 && inh_len < 20000) begin inh_len++; cyc(1); end
        rts_ok = (ps2_dat === 1'b0);
        cyc(10);
        for (int k = 1; k <= 10 && k <= npulses; k++) begin
            dev_clk_lo = 1'b1;
            cyc(20);
            dev_clk_lo = 1'b0;
            bits[k] = ps2_dat;
            cyc(20);
        end
        if (npulses >= 11) begin
            dev_dat_lo = do_ack;
            cyc(10);
            dev_clk_lo = 1'b1;
            cyc(20);
            dev_clk_lo = 1'b0;
            cyc(10);
            dev_dat_lo = 1'b0;
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, rx_q[i], exp_q[i]);
    endtask

    task automatic check_tx(input string tag, input logic [7:0] cmd, input logic [10:0] bits,
                            input int inh_len, input bit rts_ok, input bit found);
        check({tag, "_found"}, found, 1);
        check({tag, "_inhibit_len"}, inh_len, INHIBIT);
        check({tag, "_rts_dat_low"}, rts_ok, 1);
        check({tag, "_data"}, bits[8:1], cmd);
        check({tag, "_parity"}, bits[9], ($countones(cmd) % 2) == 0);
        check({tag, "_stop"}, bits[10], 1);
    endtask

    logic [10:0] bits1, bits2;
    int inh1, inh2, t, sent0, err0;
    bit rts1, rts2, fnd1, fnd2;
    logic [7:0] rb, rcmd;
    int kind;

    initial begin
        bus.the_command = 8'h00;
        bus.send_command = 1'b0;
        cyc(5);
        check("reset_rx_data", bus.received_data, 8'h00);
        check("reset_rx_en", bus.received_data_en, 0);
        check("reset_sent", bus.command_was_sent, 0);
        check("reset_err", bus.error_communication_timed_out, 0);
        check("reset_clk_released", ps2_clk, 1);
        check("reset_dat_released", ps2_dat, 1);
        reset_n = 1'b1;
        cyc(5);

        send_frame(8'hFA, 0, 0, 11);
        cyc(5);
        compare_rx("rx_fa");
        check("rx_fa_data_out", bus.received_data, 8'hFA);

        send_frame(8'h08, 1, 0, 11);
        cyc(5);
        compare_rx("rx_bad_parity");
        check("rx_bad_parity_hold", bus.received_data, 8'hFA);

        send_frame(8'h08, 0, 0, 11);
        send_frame(8'h05, 0, 0, 11);
        send_frame(8'hFD, 0, 0, 11);
        cyc(5);
        compare_rx("rx_b2b");

        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            send_frame(rb, kind == 1, kind == 2, 11);
            cyc($urandom_range(0, 30));
        end
        cyc(5);
        compare_rx("rx_random");

        send_frame(8'h77, 0, 0, 4);
        cyc(RX_TO + 50);
        send_frame(8'h3C, 0, 0, 11);
        cyc(5);
        compare_rx("rx_timeout_recover");

        sent0 = sent_cnt;
        err0 = err_cnt;
        bus.the_command = 8'hF4;
        bus.send_command = 1'b1;
        dev_host_rx(11, 1, bits1, inh1, rts1, fnd1);
        cyc(20);
        check_tx("tx_f4", 8'hF4, bits1, inh1, rts1, fnd1);
        check("tx_f4_sent", sent_cnt - sent0, 1);
        check("tx_f4_no_err", err_cnt - err0, 0);
        cyc(START_TO + 200);
        check("no_retrigger_sent", sent_cnt - sent0, 1);
        check("no_retrigger_err", err_cnt - err0, 0);
        bus.send_command = 1'b0;
        cyc(3);

        rcmd = 8'($urandom_range(0, 255));
        sent0 = sent_cnt;
        bus.the_command = rcmd;
        bus.send_command = 1'b1;
        dev_host_rx(11, 1, bits1, inh1, rts1, fnd1);
        cyc(20);
        check_tx("tx_rand", rcmd, bits1, inh1, rts1, fnd1);
        check("tx_rand_sent", sent_cnt - sent0, 1);
        bus.send_command = 1'b0;
        cyc(3);

        sent0 = sent_cnt;
        err0 = err_cnt;
        bus.the_command = 8'hFF;
        bus.send_command = 1'b1;
        dev_host_rx(11, 0, bits1, inh1, rts1, fnd1);
        cyc(20);
        check("no_ack_err", err_cnt - err0, 1);
        check("no_ack_sent", sent_cnt - sent0, 0);
        check("no_ack_dat_released", ps2_dat, 1);
        bus.send_command = 1'b0;
        cyc(3);

        sent0 = sent_cnt;
        err0 = err_cnt;
        bus.the_command = 8'hA5;
        bus.send_command = 1'b1;
        t = 0;
        while (ps2_clk !== 1'b0 && t < 1000) begin cyc(1); t++; end
        t = 0;
        while (ps2_clk !== 1'b1 && t < 1000) begin cyc(1); t++; end
        t = 0;
        while (bus.error_communication_timed_out !== 1'b1 && t < START_TO + 200) begin cyc(1); t++; end
        check("start_timeout_window", (t >= START_TO) && (t <= START_TO + 3), 1);
        check("start_timeout_clk_released", ps2_clk, 1);
        check("start_timeout_dat_released", ps2_dat, 1);
        cyc(5);
        check("start_timeout_err", err_cnt - err0, 1);
        check("start_timeout_sent", sent_cnt - sent0, 0);
        bus.send_command = 1'b0;
        cyc(3);

        sent0 = sent_cnt;
        bus.the_command = 8'h3C;
        bus.send_command = 1'b1;
        fork
            dev_host_rx(11, 1, bits1, inh1, rts1, fnd1);
            begin
                cyc(200);
                bus.send_command = 1'b0;
                cyc(2);
                bus.the_command = 8'hC3;
                bus.send_command = 1'b1;
                cyc(2);
                bus.the_command = 8'h00;
            end
        join
        dev_host_rx(11, 1, bits2, inh2, rts2, fnd2);
        cyc(20);
        check_tx("tx_first", 8'h3C, bits1, inh1, rts1, fnd1);
        check_tx("tx_latched", 8'hC3, bits2, inh2, rts2, fnd2);
        check("tx_latched_sent", sent_cnt - sent0, 2);
        bus.send_command = 1'b0;
        cyc(3);

        bus.the_command = 8'hF4;
        bus.send_command = 1'b1;
        dev_host_rx(4, 1, bits1, inh1, rts1, fnd1);
        check("mid_send_dat_driven", ps2_dat, 0);
        reset_n = 1'b0;
        bus.send_command = 1'b0;
        #1;
        check("reset_mid_clk", ps2_clk, 1);
        check("reset_mid_dat", ps2_dat, 1);
        check("reset_mid_rx_data", bus.received_data, 8'h00);
        check("reset_mid_outputs", {bus.received_data_en, bus.command_was_sent,
                                    bus.error_communication_timed_out}, 3'b000);
        cyc(3);
        reset_n = 1'b1;
        cyc(10);
        send_frame(8'h5A, 0, 0, 11);
        cyc(5);
        compare_rx("rx_after_reset");
        check("rx_after_reset_data", bus.received_data, 8'h5A);

        check("strobe_width", en_max, 1);
        check("sent_width", sent_max, 1);
        check("err_width", err_max, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
